// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - decode-side bundle between the pipeline and the forwarding/hazard unit
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_rs1_use_i;
    logic              id_rs2_use_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwr_i;
    logic              id_memrd_i;
    logic              flush_i;
    logic              freeze_i;
    logic              cnt_clr_i;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
               id_rd_i, id_regwr_i, id_memrd_i, flush_i, freeze_i, cnt_clr_i,
        input  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
               id_rd_i, id_regwr_i, id_memrd_i, flush_i, freeze_i, cnt_clr_i,
        output fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall generation
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fwd_hazard_unit_if.slave bus
);
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              regwr;
        logic              memrd;
    } slot_t;

    slot_t            s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic             a1, a2, a3, b1, b2, b3;
    logic             stall;

    function automatic logic hit(slot_t s, logic [REG_AW-1:0] r, logic use_bit);
        return s.v & s.regwr & (s.rd == r) & (r != '0) & use_bit;
    endfunction

    always_comb begin
        a1 = hit(s1, bus.id_rs1_i, bus.id_rs1_use_i);
        a2 = hit(s2, bus.id_rs1_i, bus.id_rs1_use_i);
        a3 = hit(s3, bus.id_rs1_i, bus.id_rs1_use_i);
        b1 = hit(s1, bus.id_rs2_i, bus.id_rs2_use_i);
        b2 = hit(s2, bus.id_rs2_i, bus.id_rs2_use_i);
        b3 = hit(s3, bus.id_rs2_i, bus.id_rs2_use_i);
        // Load data only becomes forwardable from MEM/WB, so loads in S1/S2 must stall.
        stall = bus.id_valid_i & ((s1.memrd & (a1 | b1)) | (s2.memrd & (a2 | b2)));
    end

    assign bus.fwd_a_o     = a1 ? 2'b01 : a2 ? 2'b10 : a3 ? 2'b11 : 2'b00;
    assign bus.fwd_b_o     = b1 ? 2'b01 : b2 ? 2'b10 : b3 ? 2'b11 : 2'b00;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
            cnt <= '0;
        end else if (!bus.freeze_i) begin
            s3 <= s2;
            s2 <= s1;
            if (bus.flush_i | stall | ~bus.id_valid_i)
                s1 <= '0;
            else
                s1 <= '{v: 1'b1, rd: bus.id_rd_i, regwr: bus.id_regwr_i, memrd: bus.id_memrd_i};
            if (bus.cnt_clr_i)
                cnt <= '0;
            else if (stall && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end
endmodule
